// File: rtl/chip_clk_sched.sv
// chip_clk_sched: programmable reference divider driving CH_NUM glitch-free
// gated chip clocks. Each channel either runs free under ch_on or emits an
// exact burst of burst_len pulses. Gates only move at the start of a
// reference high half, so every emitted pulse is a full period.
module chip_clk_sched #(
  parameter int unsigned CH_NUM  = 8,
  parameter int unsigned DIV_W   = 8,
  parameter int unsigned DEF_DIV = 0,
  parameter int unsigned CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DIV_W-1:0]  div_cfg,
  input  logic              div_load,
  input  logic [CH_NUM-1:0] ch_on,
  input  logic [CH_NUM-1:0] burst_start,
  input  logic [CNT_W-1:0]  burst_len,
  output logic [CH_NUM-1:0] clk_out,
  output logic [CH_NUM-1:0] ch_busy,
  output logic [CH_NUM-1:0] burst_done,
  output logic              tick
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_BURST = 2'b10
  } ch_state_e;

  localparam logic [DIV_W-1:0] DIV_RST  = DIV_W'(DEF_DIV);
  localparam logic [DIV_W-1:0] DIV_ZERO = {DIV_W{1'b0}};
  localparam logic [DIV_W-1:0] DIV_ONE  = {{(DIV_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] REM_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] REM_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  // Reference divider state
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] div_pend_q, div_pend_d;
  logic             phase_q, phase_d;
  logic             wrap_s;
  logic             pstart_s;

  // Per-channel state
  ch_state_e        state_q [CH_NUM];
  ch_state_e        state_d [CH_NUM];
  logic [CNT_W-1:0] rem_q   [CH_NUM];
  logic [CNT_W-1:0] rem_d   [CH_NUM];
  logic [CH_NUM-1:0] pend_q, pend_d;

  // Registered outputs
  logic [CH_NUM-1:0] clk_out_q, clk_out_d;
  logic [CH_NUM-1:0] ch_busy_q, ch_busy_d;
  logic [CH_NUM-1:0] burst_done_q, burst_done_d;
  logic              tick_q, tick_d;

  // Divider next state: count to div_q, toggle phase on wrap; a new ratio
  // is adopted only where a high half begins so the running period completes.
  always_comb begin
    wrap_s   = (div_cnt_q == div_q);
    pstart_s = wrap_s & ~phase_q;
    if (wrap_s) begin
      div_cnt_d = DIV_ZERO;
      phase_d   = ~phase_q;
    end else begin
      div_cnt_d = div_cnt_q + DIV_ONE;
      phase_d   = phase_q;
    end
    if (div_load) begin
      div_pend_d = div_cfg;
    end else begin
      div_pend_d = div_pend_q;
    end
    if (pstart_s) begin
      div_d = div_pend_q;
    end else begin
      div_d = div_q;
    end
    tick_d = pstart_s;
  end

  // Divider registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q  <= DIV_ZERO;
      div_q      <= DIV_RST;
      div_pend_q <= DIV_RST;
      phase_q    <= 1'b0;
      tick_q     <= 1'b0;
    end else begin
      div_cnt_q  <= div_cnt_d;
      div_q      <= div_d;
      div_pend_q <= div_pend_d;
      phase_q    <= phase_d;
      tick_q     <= tick_d;
    end
  end

  // Channel FSMs: all decisions that move a gate are taken on pstart, when
  // the output is low; the burst counter holds pulses left after the current one.
  always_comb begin
    clk_out_d    = {CH_NUM{1'b0}};
    ch_busy_d    = {CH_NUM{1'b0}};
    burst_done_d = {CH_NUM{1'b0}};
    pend_d       = pend_q;
    for (int i = 0; i < CH_NUM; i++) begin
      state_d[i] = state_q[i];
      rem_d[i]   = rem_q[i];
      case (state_q[i])
        ST_IDLE: begin
          if (pstart_s && pend_q[i]) begin
            pend_d[i] = 1'b0;
            if (rem_q[i] == REM_ZERO) begin
              burst_done_d[i] = 1'b1;
            end else begin
              state_d[i] = ST_BURST;
              rem_d[i]   = rem_q[i] - REM_ONE;
            end
          end else if (pstart_s && ch_on[i]) begin
            state_d[i] = ST_RUN;
          end else if (burst_start[i] && !pend_q[i]) begin
            rem_d[i]  = burst_len;
            pend_d[i] = 1'b1;
          end else begin
            state_d[i] = ST_IDLE;
          end
        end
        ST_RUN: begin
          if (pstart_s && !ch_on[i]) begin
            state_d[i] = ST_IDLE;
          end else begin
            state_d[i] = ST_RUN;
          end
        end
        ST_BURST: begin
          if (pstart_s) begin
            if (rem_q[i] == REM_ZERO) begin
              state_d[i]      = ST_IDLE;
              burst_done_d[i] = 1'b1;
            end else begin
              rem_d[i] = rem_q[i] - REM_ONE;
            end
          end else begin
            state_d[i] = ST_BURST;
          end
        end
        default: begin
          state_d[i] = ST_IDLE;
          rem_d[i]   = REM_ZERO;
          pend_d[i]  = 1'b0;
        end
      endcase
      clk_out_d[i] = phase_d & (state_d[i] != ST_IDLE);
      ch_busy_d[i] = pend_q[i] | (state_q[i] != ST_IDLE);
    end
  end

  // Channel registers and gated outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CH_NUM; i++) begin
        state_q[i] <= ST_IDLE;
        rem_q[i]   <= REM_ZERO;
      end
      pend_q       <= {CH_NUM{1'b0}};
      clk_out_q    <= {CH_NUM{1'b0}};
      ch_busy_q    <= {CH_NUM{1'b0}};
      burst_done_q <= {CH_NUM{1'b0}};
    end else begin
      for (int i = 0; i < CH_NUM; i++) begin
        state_q[i] <= state_d[i];
        rem_q[i]   <= rem_d[i];
      end
      pend_q       <= pend_d;
      clk_out_q    <= clk_out_d;
      ch_busy_q    <= ch_busy_d;
      burst_done_q <= burst_done_d;
    end
  end

  assign clk_out    = clk_out_q;
  assign ch_busy    = ch_busy_q;
  assign burst_done = burst_done_q;
  assign tick       = tick_q;

endmodule

// File: tb/tb_chip_clk_sched.sv
// Directed bench for chip_clk_sched with default parameters (8 ch, DEF_DIV=0).
module tb_chip_clk_sched;

  logic        clk;
  logic        rst_n;
  logic [7:0]  div_cfg;
  logic        div_load;
  logic [7:0]  ch_on;
  logic [7:0]  burst_start;
  logic [15:0] burst_len;
  logic [7:0]  clk_out;
  logic [7:0]  ch_busy;
  logic [7:0]  burst_done;
  logic        tick;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  chip_clk_sched dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .div_cfg     (div_cfg),
    .div_load    (div_load),
    .ch_on       (ch_on),
    .burst_start (burst_start),
    .burst_len   (burst_len),
    .clk_out     (clk_out),
    .ch_busy     (ch_busy),
    .burst_done  (burst_done),
    .tick        (tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d: observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  // one rising edge, then sample 1 time unit later
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // reset with all inputs idle; release right after an edge so the next
  // edge is cycle 1
  task automatic do_reset();
    rst_n       = 1'b0;
    div_cfg     = 8'd0;
    div_load    = 1'b0;
    ch_on       = 8'h00;
    burst_start = 8'h00;
    burst_len   = 16'd0;
    step();
    step();
    rst_n = 1'b1;
    cyc   = 0;
  endtask

  initial begin
    logic [7:0] e8;
    logic       eb;
    logic       prev;
    int         edges;

    // reset state
    do_reset();
    chk("rst_clk_out", 32'(clk_out), 32'h0);
    chk("rst_ch_busy", 32'(ch_busy), 32'h0);
    chk("rst_burst_done", 32'(burst_done), 32'h0);
    chk("rst_tick", 32'(tick), 32'h0);

    // 1: ch0 free-run at core/2
    ch_on = 8'h01;
    while (cyc < 6) begin
      step();
      e8 = cyc[0] ? 8'h01 : 8'h00;
      chk("t1_clk_out", 32'(clk_out), 32'(e8));
      chk("t1_tick", 32'(tick), 32'(cyc[0]));
      chk("t1_ch_busy", 32'(ch_busy), (cyc >= 2) ? 32'h01 : 32'h00);
    end

    // 2: ratio change while ch0 runs
    step();
    chk("t2_old_high", 32'(clk_out), 32'h01);
    div_cfg  = 8'd3;
    div_load = 1'b1;
    step();
    div_load = 1'b0;
    chk("t2_old_low", 32'(clk_out), 32'h00);
    while (cyc < 17) begin
      step();
      eb = ((cyc >= 9) && (cyc <= 12)) || (cyc == 17);
      chk("t2_clk_out", 32'(clk_out), 32'(eb));
      chk("t2_tick", 32'(tick), 32'((cyc == 9) || (cyc == 17)));
    end

    // 3: burst of 5 on ch2 at div=1
    do_reset();
    div_cfg  = 8'd1;
    div_load = 1'b1;
    step();
    div_load = 1'b0;
    step();
    step();
    chk("t3_tick_k3", 32'(tick), 32'h1);
    burst_start = 8'h04;
    burst_len   = 16'd5;
    step();
    burst_start = 8'h00;
    chk("t3_busy_k4", 32'(ch_busy), 32'h00);
    prev  = clk_out[2];
    edges = 0;
    while (cyc < 29) begin
      step();
      eb = (cyc >= 7) && (cyc <= 24) && (((cyc - 7) % 4) < 2);
      chk("t3_clk_out", 32'(clk_out), eb ? 32'h04 : 32'h00);
      chk("t3_burst_done", 32'(burst_done), (cyc == 27) ? 32'h04 : 32'h00);
      chk("t3_ch_busy", 32'(ch_busy), ((cyc >= 5) && (cyc <= 27)) ? 32'h04 : 32'h00);
      chk("t3_tick", 32'(tick), 32'(((cyc - 3) % 4) == 0));
      if (clk_out[2] && !prev) edges++;
      prev = clk_out[2];
    end
    chk("t3_edges", 32'(edges), 32'd5);

    // 4: ch1 dropped in the 2nd cycle of a 4-cycle high half
    do_reset();
    div_cfg  = 8'd3;
    div_load = 1'b1;
    ch_on    = 8'h02;
    step();
    div_load = 1'b0;
    while (cyc < 10) step();
    while (cyc < 26) begin
      step();
      chk("t4_clk_out", 32'(clk_out), ((cyc >= 11) && (cyc <= 14)) ? 32'h02 : 32'h00);
      chk("t4_ch_busy", 32'(ch_busy), (cyc <= 19) ? 32'h02 : 32'h00);
      chk("t4_tick", 32'(tick), 32'((cyc == 11) || (cyc == 19)));
      if (cyc == 12) ch_on = 8'h00;
    end

    // 5a: zero-length burst on ch3, requested in a pstart cycle
    do_reset();
    burst_start = 8'h08;
    burst_len   = 16'd0;
    step();
    burst_start = 8'h00;
    chk("t5a_clk_out_k1", 32'(clk_out), 32'h00);
    while (cyc < 4) begin
      step();
      chk("t5a_clk_out", 32'(clk_out), 32'h00);
      chk("t5a_burst_done", 32'(burst_done), (cyc == 3) ? 32'h08 : 32'h00);
      chk("t5a_ch_busy", 32'(ch_busy), ((cyc == 2) || (cyc == 3)) ? 32'h08 : 32'h00);
    end
    // 5b: burst of 2 and ch_on together on ch4; burst first, then RUN
    step();
    burst_start = 8'h10;
    burst_len   = 16'd2;
    ch_on       = 8'h10;
    step();
    burst_start = 8'h00;
    while (cyc < 16) begin
      step();
      eb = (cyc == 7) || (cyc == 9) || (cyc == 13) || (cyc == 15);
      chk("t5b_clk_out", 32'(clk_out), eb ? 32'h10 : 32'h00);
      chk("t5b_burst_done", 32'(burst_done), (cyc == 11) ? 32'h10 : 32'h00);
    end

    // 6: async reset in the middle of a 10-pulse burst on ch5 at div=2
    do_reset();
    div_cfg  = 8'd2;
    div_load = 1'b1;
    step();
    div_load = 1'b0;
    while (cyc < 3) step();
    burst_start = 8'h20;
    burst_len   = 16'd10;
    step();
    burst_start = 8'h00;
    while (cyc < 10) step();
    chk("t6_running_clk", 32'(clk_out), 32'h20);
    chk("t6_running_busy", 32'(ch_busy), 32'h20);
    rst_n = 1'b0;
    #2;
    chk("t6_async_clk_out", 32'(clk_out), 32'h00);
    chk("t6_async_ch_busy", 32'(ch_busy), 32'h00);
    chk("t6_async_burst_done", 32'(burst_done), 32'h00);
    step();
    rst_n = 1'b1;
    cyc   = 0;
    while (cyc < 30) begin
      step();
      chk("t6_clk_out", 32'(clk_out), 32'h00);
      chk("t6_ch_busy", 32'(ch_busy), 32'h00);
      chk("t6_burst_done", 32'(burst_done), 32'h00);
      chk("t6_tick_defdiv", 32'(tick), 32'(cyc[0]));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
